block_accumulator: RTL and testbench

//  Downstream stage of the sample-capture register: consumes 8-bit captured samples

---
 rtl/acc_pkg.sv | 11 +
 rtl/sat_adder.sv | 16 +
 rtl/block_accumulator.sv | 84 ++++++++
 tb/tb_block_accumulator.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// acc_pkg: shared state encoding and sizing helper for the block accumulator
package acc_pkg;
   localparam logic [0:0] ACCUM = 1'b0;
   localparam logic [0:0] HOLD  = 1'b1;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/sat_adder.sv
// sat_adder: unsigned add of a narrow addend into a running sum, clamped to all-ones
module sat_adder #(
   parameter int A_W = 8,
   parameter int S_W = 12
) (
   input  logic [S_W-1:0] sum_i,
   input  logic [A_W-1:0] addend_i,
   output logic [S_W-1:0] sum_o,
   output logic           sat_o
);
   localparam int W = (A_W > S_W ? A_W : S_W) + 1;
   logic [W-1:0] full;
   assign full  = W'(sum_i) + W'(addend_i);
   assign sat_o = |full[W-1:S_W];
   assign sum_o = sat_o ? '1 : full[S_W-1:0];
endmodule

// File: rtl/block_accumulator.sv
// block_accumulator: sums BLOCK_LEN samples per result, holding each result until accepted
module block_accumulator
   import acc_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int BLOCK_LEN = 16,
   parameter int SUM_W     = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [SUM_W-1:0]  out_sum,
   output logic              out_sat,
   input  logic              out_ready
);
   localparam int CNT_W = clog2(BLOCK_LEN) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);
   logic [0:0]       state_q, state_d;
   logic [SUM_W-1:0] sum_q, sum_d, out_sum_q, out_sum_d, add_sum;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d, out_valid_q, out_valid_d, out_sat_q, out_sat_d, add_sat;
   sat_adder #(.A_W(DATA_W), .S_W(SUM_W)) u_add (
      .sum_i(sum_q), .addend_i(in_data), .sum_o(add_sum), .sat_o(add_sat)
   );
   assign in_ready = state_q == ACCUM;
   // HOLD has two phases: load the output registers, then wait for the consumer
   always_comb begin
      state_d     = state_q;
      sum_d       = sum_q;
      cnt_d       = cnt_q;
      sat_d       = sat_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_sat_d   = out_sat_q;
      if (clear) begin
         state_d     = ACCUM;
         sum_d       = '0;
         cnt_d       = '0;
         sat_d       = 1'b0;
         out_valid_d = 1'b0;
      end else if (in_ready && in_valid) begin
         sum_d   = add_sum;
         sat_d   = sat_q | add_sat;
         cnt_d   = cnt_q == LAST ? '0 : cnt_q + CNT_W'(1);
         state_d = cnt_q == LAST ? HOLD : ACCUM;
      end else if (state_q == HOLD && !out_valid_q) begin
         out_valid_d = 1'b1;
         out_sum_d   = sum_q;
         out_sat_d   = sat_q;
      end else if (state_q == HOLD && out_ready) begin
         state_d     = ACCUM;
         sum_d       = '0;
         cnt_d       = '0;
         sat_d       = 1'b0;
         out_valid_d = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ACCUM;
         sum_q       <= '0;
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         cnt_q       <= cnt_d;
         sat_q       <= sat_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_sat_q   <= out_sat_d;
      end
   end
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_block_accumulator.sv
// tb_block_accumulator: table-driven and scoreboard checks of block_accumulator at SUM_W 12 and 10
module tb_block_accumulator;
   logic clk = 1'b0;
   logic rst, clear, in_valid, out_ready;
   logic [7:0] in_data;
   logic in_ready, out_valid, out_sat, in_ready10, out_valid10, out_sat10;
   logic [11:0] out_sum;
   logic [9:0] out_sum10;
   int tests = 0, fails = 0, pulses = 0;

   typedef struct { logic [11:0] sum; logic sat; } exp_t;
   typedef struct { logic [7:0] v; logic [11:0] e12; logic s12; logic [9:0] e10; logic s10; } vec_t;
   exp_t q12[$], q10[$];

   always #5 clk = ~clk;

   block_accumulator dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_sum(out_sum), .out_sat(out_sat),
      .out_ready(out_ready)
   );
   block_accumulator #(.SUM_W(10)) dut10 (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready10), .out_valid(out_valid10), .out_sum(out_sum10), .out_sat(out_sat10),
      .out_ready(out_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // scoreboards pop on every completed output handshake
   always @(posedge clk) begin
      if (!rst && !clear && out_valid && out_ready) begin
         pulses++;
         if (q12.size() == 0) chk("sb12_unexpected", 32'(out_sum), 32'hFFFF_FFFF);
         else begin
            exp_t e;
            e = q12.pop_front();
            chk("sb12_sum", 32'(out_sum), 32'(e.sum));
            chk("sb12_sat", 32'(out_sat), 32'(e.sat));
         end
      end
      if (!rst && !clear && out_valid10 && out_ready) begin
         if (q10.size() == 0) chk("sb10_unexpected", 32'(out_sum10), 32'hFFFF_FFFF);
         else begin
            exp_t e;
            e = q10.pop_front();
            chk("sb10_sum", 32'(out_sum10), 32'(e.sum));
            chk("sb10_sat", 32'(out_sat10), 32'(e.sat));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] v);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = v;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) chk("send_timeout", 32'(n), 32'd0);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) chk(name, 32'(out_valid), 32'd1);
   endtask

   task automatic push(input logic [11:0] e12, input logic s12, input logic [11:0] e10, input logic s10);
      q12.push_back('{e12, s12});
      q10.push_back('{e10, s10});
   endtask

   initial begin
      vec_t tbl[7];
      int p0;
      tbl[0] = '{8'h01, 12'h010, 1'b0, 10'h010, 1'b0};
      tbl[1] = '{8'hFF, 12'hFF0, 1'b0, 10'h3FF, 1'b1};
      tbl[2] = '{8'h00, 12'h000, 1'b0, 10'h000, 1'b0};
      tbl[3] = '{8'h40, 12'h400, 1'b0, 10'h3FF, 1'b1};
      tbl[4] = '{8'h3F, 12'h3F0, 1'b0, 10'h3F0, 1'b0};
      tbl[5] = '{8'h80, 12'h800, 1'b0, 10'h3FF, 1'b1};
      tbl[6] = '{8'h10, 12'h100, 1'b0, 10'h100, 1'b0};
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (2) tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sum", 32'(out_sum), 32'd0);
      chk("rst_out_sat", 32'(out_sat), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;
      tick();
      // back-to-back ones: in_ready low for exactly two cycles around the result
      push(12'h010, 1'b0, 12'h010, 1'b0);
      for (int i = 0; i < 16; i++) send(8'h01);
      chk("t1_ready_lo_a", 32'(in_ready), 32'd0);
      chk("t1_valid_lat_a", 32'(out_valid), 32'd0);
      tick();
      chk("t1_valid_lat_b", 32'(out_valid), 32'd1);
      chk("t1_sum", 32'(out_sum), 32'h010);
      chk("t1_sat", 32'(out_sat), 32'd0);
      chk("t1_ready_lo_b", 32'(in_ready), 32'd0);
      tick();
      chk("t1_ready_back", 32'(in_ready), 32'd1);
      chk("t1_valid_drop", 32'(out_valid), 32'd0);
      // table of constant-value blocks
      for (int k = 0; k < 7; k++) begin
         push(tbl[k].e12, tbl[k].s12, 12'(tbl[k].e10), tbl[k].s10);
         for (int i = 0; i < 16; i++) send(tbl[k].v);
         wait_valid("tbl_timeout");
         chk("tbl_sum12", 32'(out_sum), 32'(tbl[k].e12));
         chk("tbl_sat12", 32'(out_sat), 32'(tbl[k].s12));
         chk("tbl_sum10", 32'(out_sum10), 32'(tbl[k].e10));
         chk("tbl_sat10", 32'(out_sat10), 32'(tbl[k].s10));
         tick();
      end
      // backpressure: result held, in_valid ignored
      out_ready = 1'b0;
      push(12'h030, 1'b0, 12'h030, 1'b0);
      for (int i = 0; i < 16; i++) send(8'h03);
      in_valid = 1'b1; in_data = 8'h77;
      wait_valid("t3_timeout");
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_valid", 32'(out_valid), 32'd1);
         chk("t3_hold_sum", 32'(out_sum), 32'h030);
         chk("t3_hold_ready", 32'(in_ready), 32'd0);
         tick();
      end
      out_ready = 1'b1;
      chk("t3_ready_still_lo", 32'(in_ready), 32'd0);
      tick();
      in_valid = 1'b0;
      chk("t3_ready_back", 32'(in_ready), 32'd1);
      chk("t3_valid_drop", 32'(out_valid), 32'd0);
      push(12'h010, 1'b0, 12'h010, 1'b0);
      for (int i = 0; i < 16; i++) send(8'h01);
      wait_valid("t3b_timeout");
      tick();
      // clear mid-block, with a sample presented in the clear cycle
      push(12'h020, 1'b0, 12'h020, 1'b0);
      for (int i = 0; i < 7; i++) send(8'h05);
      in_valid = 1'b1; in_data = 8'h05; clear = 1'b1;
      tick();
      in_valid = 1'b0; clear = 1'b0;
      chk("t4_ready", 32'(in_ready), 32'd1);
      chk("t4_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 16; i++) send(8'h02);
      wait_valid("t4_timeout");
      chk("t4_sum", 32'(out_sum), 32'h020);
      tick();
      // reset while holding a saturated result
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) send(8'hFF);
      wait_valid("t5_timeout");
      chk("t5_pre_sat10", 32'(out_sat10), 32'd1);
      rst = 1'b1;
      tick();
      chk("t5_valid", 32'(out_valid), 32'd0);
      chk("t5_sum", 32'(out_sum), 32'd0);
      chk("t5_sat10", 32'(out_sat10), 32'd0);
      chk("t5_sum10", 32'(out_sum10), 32'd0);
      chk("t5_ready", 32'(in_ready), 32'd1);
      rst = 1'b0; out_ready = 1'b1;
      tick();
      // samples 1..16 with random gaps
      push(12'h088, 1'b0, 12'h088, 1'b0);
      p0 = pulses;
      for (int i = 1; i <= 16; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         send(8'(i));
      end
      wait_valid("t6_timeout");
      chk("t6_sum", 32'(out_sum), 32'h088);
      repeat (4) tick();
      chk("t6_pulses", 32'(pulses - p0), 32'd1);
      chk("q12_drained", 32'(q12.size()), 32'd0);
      chk("q10_drained", 32'(q10.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
